// File: rtl/i2s_sample_feeder_pkg.sv
// Shared I2S timing constants for the 50 MHz / 48 kHz transmit path.
// These constants were previously supplied through i2s_defs.vh, which the serialiser and receiver also used.
package i2s_sample_feeder_pkg;

    localparam int unsigned DEF_SAMPLE_W    = 24;
    localparam int unsigned DEF_ACC_W       = 32;
    localparam int unsigned DEF_ACC_INC     = 395824186;
    localparam int unsigned DEF_BCLK_PER_CH = 24;
    localparam int unsigned DEF_FIFO_DEPTH  = 8;

    typedef enum logic {
        SLOT_LEFT  = 1'b0,
        SLOT_RIGHT = 1'b1
    } slot_e;

endpackage

// File: rtl/i2s_sample_feeder_sync_fifo.sv
// Single-clock FIFO holding stereo sample pairs.
// The read data is the head entry, presented combinationally.
module i2s_sample_feeder_sync_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       full,
    output logic                       empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (level == (AW+1)'(DEPTH));
        empty   = (level == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;
        rdata   = mem[rptr];
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) begin
                wptr <= wptr + AW'(1);
            end
            if (do_pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + (AW+1)'(1);
                2'b01:   level <= level - (AW+1)'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/i2s_sample_feeder.sv
// I2S transmit feeder: phase-accumulator bclk/daclrc generation, sample-pair FIFO,
// and slot-aligned presentation of the current channel word to the serialiser.
module i2s_sample_feeder
    import i2s_sample_feeder_pkg::*;
#(
    parameter int unsigned SAMPLE_W    = DEF_SAMPLE_W,
    parameter int unsigned FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter int unsigned ACC_W       = DEF_ACC_W,
    parameter int unsigned ACC_INC     = DEF_ACC_INC,
    parameter int unsigned BCLK_PER_CH = DEF_BCLK_PER_CH
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [SAMPLE_W-1:0]           s_left,
    input  logic [SAMPLE_W-1:0]           s_right,
    output logic                          bclk,
    output logic                          daclrc,
    output logic [SAMPLE_W-1:0]           audio_data,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic [15:0]                   underrun_cnt
);

    localparam int unsigned CNT_W = $clog2(BCLK_PER_CH);
    localparam logic [ACC_W-1:0] INC      = ACC_W'(ACC_INC);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(BCLK_PER_CH - 1);

    logic [ACC_W-1:0]      acc;
    logic [ACC_W:0]        acc_sum;
    logic [CNT_W-1:0]      bitcnt;
    slot_e                 slot;
    logic [SAMPLE_W-1:0]   right_hold;
    logic                  fall_tog;
    logic                  slot_tog;
    logic                  frame_start;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [2*SAMPLE_W-1:0] fifo_rdata;

    always_comb begin
        acc_sum     = {1'b0, acc} + {1'b0, INC};
        fall_tog    = enable && acc_sum[ACC_W] && bclk;
        slot_tog    = fall_tog && (bitcnt == LAST_BIT);
        frame_start = slot_tog && (slot == SLOT_RIGHT);
        fifo_pop    = frame_start && !fifo_empty;
        s_ready     = !fifo_full;
        fifo_push   = s_valid && s_ready;
    end

    assign daclrc = slot;

    i2s_sample_feeder_sync_fifo #(
        .WIDTH (2*SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .wdata ({s_left, s_right}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Idling parks in the right slot so the first slot after enable is a fresh left pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc          <= '0;
            bitcnt       <= '0;
            bclk         <= 1'b0;
            slot         <= SLOT_RIGHT;
            audio_data   <= '0;
            right_hold   <= '0;
            underrun     <= 1'b0;
            underrun_cnt <= '0;
        end else if (!enable) begin
            acc        <= '0;
            bitcnt     <= '0;
            bclk       <= 1'b0;
            slot       <= SLOT_RIGHT;
            audio_data <= '0;
            right_hold <= '0;
            underrun   <= 1'b0;
        end else begin
            acc      <= acc_sum[ACC_W-1:0];
            underrun <= 1'b0;
            if (acc_sum[ACC_W]) begin
                bclk <= ~bclk;
            end
            if (fall_tog) begin
                bitcnt <= slot_tog ? '0 : bitcnt + CNT_W'(1);
            end
            if (slot_tog) begin
                if (slot == SLOT_RIGHT) begin
                    slot <= SLOT_LEFT;
                    if (!fifo_empty) begin
                        audio_data <= fifo_rdata[2*SAMPLE_W-1:SAMPLE_W];
                        right_hold <= fifo_rdata[SAMPLE_W-1:0];
                    end else begin
                        audio_data <= '0;
                        right_hold <= '0;
                        underrun   <= 1'b1;
                        if (underrun_cnt != '1) begin
                            underrun_cnt <= underrun_cnt + 16'd1;
                        end
                    end
                end else begin
                    slot       <= SLOT_RIGHT;
                    audio_data <= right_hold;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_sample_feeder.sv
// Bench for i2s_sample_feeder: a count-based timing model (bclk toggles = floor(n*INC/2^32))
// plus a queue of pushed pairs predicts every output cycle by cycle.
module tb_i2s_sample_feeder;

    localparam longint unsigned INC = 64'd395824186;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        s_valid;
    logic        s_ready;
    logic [23:0] s_left;
    logic [23:0] s_right;
    logic        bclk;
    logic        daclrc;
    logic [23:0] audio_data;
    logic [3:0]  fifo_level;
    logic        underrun;
    logic [15:0] underrun_cnt;

    int checks = 0;
    int errors = 0;

    // model state
    longint unsigned m_n;
    logic [23:0]     m_audio;
    logic [23:0]     m_hold;
    logic            m_under;
    int unsigned     m_cnt;
    logic [47:0]     m_q[$];

    i2s_sample_feeder dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_left       (s_left),
        .s_right      (s_right),
        .bclk         (bclk),
        .daclrc       (daclrc),
        .audio_data   (audio_data),
        .fifo_level   (fifo_level),
        .underrun     (underrun),
        .underrun_cnt (underrun_cnt)
    );

    always #10 clk = ~clk;

    function automatic longint unsigned bclk_toggles(input longint unsigned n);
        return (n * INC) >> 32;
    endfunction

    // one daclrc toggle per 48 bclk toggles (24 falling edges)
    function automatic longint unsigned lrc_toggles(input longint unsigned n);
        return bclk_toggles(n) / 48;
    endfunction

    function automatic logic exp_bclk();
        longint unsigned t;
        t = bclk_toggles(m_n);
        return t[0];
    endfunction

    function automatic logic exp_lrc();
        longint unsigned t;
        t = lrc_toggles(m_n);
        return ~t[0];
    endfunction

    function automatic bit frame_next();
        longint unsigned a;
        longint unsigned b;
        a = lrc_toggles(m_n);
        b = lrc_toggles(m_n + 1);
        return enable && (a != b) && b[0];
    endfunction

    task automatic model_reset();
        m_n = 0;
        m_audio = '0;
        m_hold = '0;
        m_under = 1'b0;
        m_cnt = 0;
        m_q.delete();
    endtask

    task automatic model_step();
        bit can_push;
        longint unsigned d0;
        longint unsigned d1;
        logic [47:0] pair;
        can_push = (m_q.size() < 8);
        if (!enable) begin
            m_n = 0;
            m_audio = '0;
            m_hold = '0;
            m_under = 1'b0;
        end else begin
            d0 = lrc_toggles(m_n);
            m_n++;
            d1 = lrc_toggles(m_n);
            m_under = 1'b0;
            if (d1 != d0) begin
                if (d1[0]) begin
                    if (m_q.size() > 0) begin
                        pair = m_q.pop_front();
                        m_audio = pair[47:24];
                        m_hold = pair[23:0];
                    end else begin
                        m_audio = '0;
                        m_hold = '0;
                        m_under = 1'b1;
                        if (m_cnt < 65535) m_cnt++;
                    end
                end else begin
                    m_audio = m_hold;
                end
            end
        end
        if (s_valid && can_push) m_q.push_back({s_left, s_right});
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({bclk, daclrc, audio_data, underrun, underrun_cnt, fifo_level, s_ready} !==
            {1'b0, 1'b1, 24'h0, 1'b0, 16'h0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_initial: got %b %b %h %b %h %h %b, want 0 1 000000 0 0000 0 1",
                     bclk, daclrc, audio_data, underrun, underrun_cnt, fifo_level, s_ready);
        end
        reset = 1'b1;
        enable = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            s_left = 24'($urandom);
            s_right = 24'($urandom);
            cycle();
        end
        s_valid = 1'b0;
        for (int i = 0; i < 400; i++) cycle();
        checks++;
        if (fifo_level !== 4'd5) begin
            errors++;
            $display("FAIL reset_prefill_level: got %0d want 5", fifo_level);
        end
        #3 reset = 1'b0;
        #1;
        checks++;
        if ({bclk, daclrc, audio_data, underrun, underrun_cnt, fifo_level, s_ready} !==
            {1'b0, 1'b1, 24'h0, 1'b0, 16'h0, 4'h0, 1'b1}) begin
            errors++;
            $display("FAIL reset_async_midframe: got %b %b %h %b %h %h %b, want 0 1 000000 0 0000 0 1",
                     bclk, daclrc, audio_data, underrun, underrun_cnt, fifo_level, s_ready);
        end
        enable = 1'b0;
        model_reset();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_single_pair();
        logic        prev_lrc;
        logic [23:0] got_l;
        logic [23:0] got_r;
        bit          found_l;
        bit          found_r;
        found_l = 0;
        found_r = 0;
        got_l = '0;
        got_r = '0;
        s_valid = 1'b1;
        s_left = 24'h123456;
        s_right = 24'hABCDEF;
        cycle();
        s_valid = 1'b0;
        checks++;
        if (fifo_level !== 4'd1) begin
            errors++;
            $display("FAIL single_level: got %0d want 1", fifo_level);
        end
        enable = 1'b1;
        prev_lrc = daclrc;
        for (int i = 0; i < 3000 && !found_r; i++) begin
            cycle();
            if (prev_lrc && !daclrc && !found_l) begin
                found_l = 1;
                got_l = audio_data;
            end else if (!prev_lrc && daclrc && found_l) begin
                found_r = 1;
                got_r = audio_data;
            end
            prev_lrc = daclrc;
        end
        checks++;
        if (!found_r || got_l !== 24'h123456 || got_r !== 24'hABCDEF) begin
            errors++;
            $display("FAIL single_pair_data: seen=%0d left %h right %h, want 123456 ABCDEF",
                     found_r, got_l, got_r);
        end
    endtask

    task automatic test_stream(input int n, input int pct);
        int   falls;
        bit   armed;
        logic pb;
        logic pl;
        falls = 0;
        armed = 0;
        pb = bclk;
        pl = daclrc;
        for (int i = 0; i < n; i++) begin
            s_valid = ($urandom_range(99) < pct);
            s_left = 24'($urandom);
            s_right = 24'($urandom);
            cycle();
            checks++;
            if ({bclk, daclrc} !== {exp_bclk(), exp_lrc()}) begin
                errors++;
                $display("FAIL stream_clocks n=%0d: got bclk/lrc %b%b want %b%b",
                         m_n, bclk, daclrc, exp_bclk(), exp_lrc());
            end
            checks++;
            if (audio_data !== m_audio) begin
                errors++;
                $display("FAIL stream_audio n=%0d: got %h want %h", m_n, audio_data, m_audio);
            end
            checks++;
            if ({underrun, underrun_cnt, fifo_level, s_ready} !==
                {m_under, 16'(m_cnt), 4'(m_q.size()), (m_q.size() < 8)}) begin
                errors++;
                $display("FAIL stream_status n=%0d: got ur=%b cnt=%0d lvl=%0d rdy=%b want ur=%b cnt=%0d lvl=%0d rdy=%b",
                         m_n, underrun, underrun_cnt, fifo_level, s_ready,
                         m_under, m_cnt, m_q.size(), (m_q.size() < 8));
            end
            if (pb && !bclk) falls++;
            if (daclrc !== pl) begin
                if (armed) begin
                    checks++;
                    if (falls != 24) begin
                        errors++;
                        $display("FAIL slot_length: got %0d bclk periods want 24", falls);
                    end
                end
                armed = 1;
                falls = 0;
            end
            pb = bclk;
            pl = daclrc;
        end
        s_valid = 1'b0;
    endtask

    task automatic test_fifo_full();
        int lvl;
        enable = 1'b0;
        cycle();
        s_valid = 1'b1;
        for (int k = 0; k < 11; k++) begin
            s_left = 24'($urandom);
            s_right = 24'($urandom);
            cycle();
            lvl = (k + 1 < 8) ? k + 1 : 8;
            checks++;
            if (fifo_level !== 4'(lvl) || s_ready !== (lvl < 8)) begin
                errors++;
                $display("FAIL fifo_fill k=%0d: got lvl=%0d rdy=%b want lvl=%0d rdy=%b",
                         k, fifo_level, s_ready, lvl, (lvl < 8));
            end
        end
        s_valid = 1'b0;
        enable = 1'b1;
    endtask

    task automatic test_underrun();
        int          pulses;
        int          exp_pulses;
        int          start_cnt;
        bit          seen;
        bit          bad_zero;
        bit          bad_width;
        logic        prev_ur;
        pulses = 0;
        exp_pulses = 0;
        start_cnt = int'(underrun_cnt);
        seen = 0;
        bad_zero = 0;
        bad_width = 0;
        prev_ur = underrun;
        s_valid = 1'b0;
        for (int i = 0; i < 2200; i++) begin
            cycle();
            if (m_under) exp_pulses++;
            if (underrun) begin
                pulses++;
                seen = 1;
                if (prev_ur) bad_width = 1;
            end
            if (seen && audio_data !== 24'h0) bad_zero = 1;
            prev_ur = underrun;
        end
        checks++;
        if (pulses != exp_pulses || pulses < 1 || bad_width) begin
            errors++;
            $display("FAIL underrun_pulses: got %0d (wide=%0d) want %0d single-clk",
                     pulses, bad_width, exp_pulses);
        end
        checks++;
        if (int'(underrun_cnt) != start_cnt + exp_pulses) begin
            errors++;
            $display("FAIL underrun_count: got %0d want %0d", underrun_cnt, start_cnt + exp_pulses);
        end
        checks++;
        if (bad_zero) begin
            errors++;
            $display("FAIL underrun_audio_zero: got nonzero audio after underrun want 000000");
        end
    endtask

    task automatic test_enable_gap();
        logic prev_lrc;
        bit   found;
        int   wait_n;
        wait_n = int'($urandom_range(600, 150));
        for (int i = 0; i < wait_n; i++) cycle();
        enable = 1'b0;
        s_valid = 1'b1;
        s_left = 24'h3C3C3C;
        s_right = 24'hC3C3C3;
        for (int i = 0; i < 100; i++) begin
            cycle();
            s_valid = 1'b0;
            checks++;
            if ({bclk, daclrc, audio_data, underrun} !== {1'b0, 1'b1, 24'h0, 1'b0}) begin
                errors++;
                $display("FAIL enable_low_hold i=%0d: got bclk=%b lrc=%b audio=%h ur=%b want 0 1 000000 0",
                         i, bclk, daclrc, audio_data, underrun);
            end
        end
        enable = 1'b1;
        found = 0;
        prev_lrc = daclrc;
        for (int i = 0; i < 2500 && !found; i++) begin
            cycle();
            if (prev_lrc && !daclrc) found = 1;
            prev_lrc = daclrc;
        end
        checks++;
        if (!found || audio_data !== 24'h3C3C3C || fifo_level !== 4'd0) begin
            errors++;
            $display("FAIL enable_first_pop: found=%0d audio=%h lvl=%0d want 3C3C3C lvl 0",
                     found, audio_data, fifo_level);
        end
    endtask

    task automatic test_back_to_back();
        bit found;
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (frame_next()) found = 1;
            else cycle();
        end
        s_valid = 1'b1;
        s_left = 24'h0A0B0C;
        s_right = 24'h0D0E0F;
        cycle();
        s_valid = 1'b0;
        checks++;
        if (!found || {underrun, fifo_level, audio_data} !== {1'b1, 4'd1, 24'h0}) begin
            errors++;
            $display("FAIL push_empty_at_pop: found=%0d got ur=%b lvl=%0d audio=%h want 1 1 000000",
                     found, underrun, fifo_level, audio_data);
        end
        found = 0;
        for (int i = 0; i < 3000 && !found; i++) begin
            if (frame_next()) found = 1;
            else cycle();
        end
        s_valid = 1'b1;
        s_left = 24'h5A5A5A;
        s_right = 24'hA5A5A5;
        cycle();
        s_valid = 1'b0;
        checks++;
        if (!found || {underrun, fifo_level, audio_data} !== {1'b0, 4'd1, 24'h0A0B0C}) begin
            errors++;
            $display("FAIL push_pop_same_clk: found=%0d got ur=%b lvl=%0d audio=%h want 0 1 0A0B0C",
                     found, underrun, fifo_level, audio_data);
        end
    endtask

    initial begin
        reset = 1'b0;
        enable = 1'b0;
        s_valid = 1'b0;
        s_left = '0;
        s_right = '0;
        model_reset();
        test_reset();
        test_single_pair();
        test_stream(1200, 0);
        test_fifo_full();
        test_stream(9000, 0);
        test_underrun();
        test_enable_gap();
        test_back_to_back();
        test_stream(5000, 50);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
